// File: rtl/serial_alu181_pkg.sv
// Shared types for the bit-serial (slice-serial) 74181 ALU.
// Holds the FSM state encoding and the named function-select codes.
package serial_alu181_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // S and X share 0110: same select, the M bit decides the meaning
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_AND = 4'b1011;
    localparam logic [3:0] S_XOR = 4'b0110;
    localparam logic [3:0] S_OR  = 4'b1110;

    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/serial_alu181_slice181.sv
// Combinational 4-bit 74181 slice, active-high data, active-high carry.
// X/Y are the chip's internal per-bit terms: arithmetic is X+Y+cin.
module slice181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] f,
    output logic       cout
);

    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;

    always_comb begin
        x = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        y = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {4'b0, cin};
        if (m) begin
            f    = ~(x ^ y);
            cout = 1'b0;
        end else begin
            f    = sum[3:0];
            cout = sum[4];
        end
    end

endmodule

// File: rtl/serial_alu181.sv
// Slice-serial 74181 ALU: one 4-bit slice per clock, carry kept
// in a register between slices, result/flags registered at done.
module serial_alu181
    import serial_alu181_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             M,
    input  logic             CNb,
    output logic [WIDTH-1:0] F,
    output logic             CN4b,
    output logic             AEB,
    output logic             busy,
    output logic             done
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = idx_width(NSLICE);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             cn4b_q, cn4b_d;
    logic             aeb_q, aeb_d;
    logic             done_q, done_d;

    logic [3:0] sl_a;
    logic [3:0] sl_b;
    logic [3:0] sl_f;
    logic       sl_cout;
    logic       last;

    assign sl_a = a_q[4*idx_q +: 4];
    assign sl_b = b_q[4*idx_q +: 4];
    assign last = (int'(idx_q) == NSLICE - 1);

    slice181 u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .s    (s_q),
        .m    (m_q),
        .cin  (carry_q),
        .f    (sl_f),
        .cout (sl_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        m_d     = m_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        f_d     = f_q;
        cn4b_d  = cn4b_q;
        aeb_d   = aeb_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    s_d     = S;
                    m_d     = M;
                    carry_d = ~CNb;
                    idx_d   = '0;
                    f_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                f_d[4*idx_q +: 4] = sl_f;
                carry_d = sl_cout;
                if (last) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    cn4b_d  = ~sl_cout;
                    aeb_d   = &f_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            f_q     <= '0;
            cn4b_q  <= 1'b1;
            aeb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            m_q     <= m_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            f_q     <= f_d;
            cn4b_q  <= cn4b_d;
            aeb_q   <= aeb_d;
            done_q  <= done_d;
        end
    end

    assign F    = f_q;
    assign CN4b = cn4b_q;
    assign AEB  = aeb_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: doc/serial_alu181.md
SERIAL_ALU181 -- requirements
Module: serial_alu181

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Derived constant NSLICE = WIDTH/4 SHALL be the number of 4-bit slices.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 A  input  WIDTH  operand A, active-high data.
REQ-007 B  input  WIDTH  operand B, active-high data.
REQ-008 S  input  4  function select, 74181 active-high table encoding.
REQ-009 M  input  1  mode: 1 = logic, 0 = arithmetic.
REQ-010 CNb  input  1  carry-in, active-low as on the 74181.
REQ-011 F  output  WIDTH  result, registered.
REQ-012 CN4b  output  1  carry-out of the top slice, active-low, registered.
REQ-013 AEB  output  1  high when every bit of F is 1, full width, registered.
REQ-014 busy  output  1  high while an operation is in progress.
REQ-015 done  output  1  one-cycle pulse marking F/CN4b/AEB valid.

Function
REQ-016 FSM states SHALL be IDLE and RUN only.
REQ-017 In IDLE with start=1 at a rising edge: latch A, B, S, M; carry register <= ~CNb; slice index <= 0; F <= 0; go to RUN; busy <= 1.
REQ-018 In RUN, each edge: evaluate one 74181 slice on A/B bits [4i+3:4i] with the current carry; write F[4i+3:4i]; carry register <= slice carry-out; index <= i+1.
REQ-019 The edge that processes slice NSLICE-1 SHALL return to IDLE, clear busy, set done=1 for exactly one cycle, and update CN4b and AEB.
REQ-020 Latency: done SHALL be high in the cycle after the (NSLICE+1)th edge counted from, and including, the start edge; WIDTH=16 gives done 5 edges after start.
REQ-021 start while busy=1 SHALL be ignored; latched operands SHALL NOT change during RUN.
REQ-022 start held high in the done cycle SHALL begin a new operation on that edge, with no idle gap.
REQ-023 Arithmetic slice: M=0 SHALL implement the 74181 active-high arithmetic column (S=1001 A plus B plus c; S=0110 A minus B minus 1 plus c; S=0000 A plus c; S=1111 A minus 1 plus c; all 16 codes), where c = inter-slice carry.
REQ-024 Logic slice: M=1 SHALL implement the 16 74181 logic functions bitwise (S=1011 A AND B; S=0110 A XOR B; S=1110 A OR B; S=0000 NOT A; and the rest); carry is ignored, and CN4b SHALL be 1.
REQ-025 Chained result SHALL equal the WIDTH-bit arithmetic modulo 2^WIDTH; CN4b = NOT(carry out of bit WIDTH-1).
REQ-026 F, CN4b and AEB SHALL hold their values from done until the next start edge.
REQ-027 F SHALL read 0 during RUN, except for slices already written.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, F=0, CN4b=1, AEB=0, busy=0, done=0, index=0 and carry=0, including mid-RUN; the aborted operation SHALL NOT produce done.
REQ-029 The first start accepted after rst deasserts SHALL behave exactly as per REQ-017.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, RUN) and the named S codes: ADD=1001, SUB=0110, AND=1011, XOR=0110, OR=1110.
REQ-031 One combinational sub-module, slice181, SHALL implement the 4-bit 74181 slice (inputs a[3:0], b[3:0], s, m, cin; outputs f[3:0], cout), instantiated once and time-multiplexed.

Verification
REQ-032 WIDTH=16, M=0, S=1001, CNb=1, A=0x0005, B=0x0007, start -> done 5 cycles later, F=0x000C, CN4b=1, AEB=0.
REQ-033 M=0, S=1001, CNb=1, A=0xFFFF, B=0x0001 -> F=0x0000, CN4b=0; carry propagates through all four slices.
REQ-034 M=1, S=1011, A=0x0F0F, B=0x3355 -> F=0x0305, CN4b=1; then M=0, S=0110, CNb=1, A=B=0x1234 -> F=0xFFFF, AEB=1, CN4b=1.
REQ-035 Start, pulse start again 2 cycles later, then assert rst on the 3rd RUN edge -> second start ignored; after rst, busy=0, done never pulses, F=0.
REQ-036 WIDTH=4: 5+7 -> done 2 cycles after start, F=0xC. Back-to-back starts at WIDTH=16 -> consecutive done pulses 5 cycles apart.
